// File: rtl/mw_sub_clk_pkg.sv
// Shared definitions for the streaming multi-word subtractor.
package mw_pkg;
  localparam int unsigned DW  = 32;
  localparam int unsigned MSB = DW - 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/mw_sub_clk_if.sv
// Operand-in / difference-out stream bundle for mw_sub_clk.
// MWSUB_OVF_EN adds the out_ovf signed-overflow flag.
interface mw_sub_clk_if #(
  parameter int unsigned CNT_W = 8
);
  import mw_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_d;
  logic [CNT_W-1:0] out_idx;
  logic             out_last;
  logic             out_borrow;
  logic             out_zero;
`ifdef MWSUB_OVF_EN
  logic             out_ovf;
`endif

  modport slave (
    input  in_valid, in_first, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_d, out_idx, out_last, out_borrow, out_zero
`ifdef MWSUB_OVF_EN
    , output out_ovf
`endif
  );

  modport master (
    output in_valid, in_first, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_d, out_idx, out_last, out_borrow, out_zero
`ifdef MWSUB_OVF_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/mw_sub_clk_cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups, lookahead carry chain across groups.
module cla32 (
  output logic [31:0] s,
  output logic        co,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_pg;
  logic [8:0]  w_cg;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_gg = '0;
    w_pg = '0;
    w_cg = '0;
    w_c  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_pg[k] = &w_p[4*k +: 4];
    end
    w_cg[0] = ci;
    for (int unsigned k = 0; k < 8; k++) begin
      w_cg[k+1] = w_gg[k] | (w_pg[k] & w_cg[k]);
    end
    // Bit carries inside a group start from that group's lookahead carry-in.
    for (int unsigned k = 0; k < 8; k++) begin
      w_c[4*k] = w_cg[k];
      for (int unsigned j = 0; j < 3; j++) begin
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      end
    end
    w_c[32] = w_cg[8];
  end

  assign s  = w_p ^ w_c[31:0];
  assign co = w_c[32];
endmodule

// File: rtl/mw_sub_clk.sv
// Streaming multi-word unsigned subtractor D = A - B, LSW first, borrow chained in a register.
// Define MWSUB_OVF_EN to add the out_ovf signed-overflow output.
module mw_sub_clk
  import mw_pkg::*;
#(
  parameter int unsigned DW    = mw_pkg::DW,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mw_sub_clk_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_valid;
  logic [DW-1:0]    r_d;
  logic [CNT_W-1:0] r_idx;
  logic             r_last;
  logic             r_borrow;
  logic             r_zero;
  logic             w_accept;
  logic             w_first;
  logic             w_cin;
  logic [DW-1:0]    w_s;
  logic             w_co;
`ifdef MWSUB_OVF_EN
  logic             r_ovf;
`endif

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;
  // Anything accepted outside an operand starts a new one, whatever in_first says.
  assign w_first      = bus.in_first || (r_state == IDLE);
  assign w_cin        = w_first ? 1'b1 : ~r_borrow;

  cla32 u_cla32 (
    .s  (w_s),
    .co (w_co),
    .a  (bus.in_a),
    .b  (~bus.in_b),
    .ci (w_cin)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = bus.in_last ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_d      <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_d      <= w_s;
        r_idx    <= w_first ? '0 : r_idx + 1'b1;
        r_last   <= bus.in_last;
        r_borrow <= ~w_co;
        r_zero   <= (w_s == '0) && (w_first || r_zero);
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef MWSUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= bus.in_last && (bus.in_a[MSB] != bus.in_b[MSB]) && (w_s[MSB] != bus.in_a[MSB]);
    end
  end

  assign bus.out_ovf = r_ovf;
`endif

  assign bus.out_valid  = r_valid;
  assign bus.out_d      = r_d;
  assign bus.out_idx    = r_idx;
  assign bus.out_last   = r_last;
  assign bus.out_borrow = r_borrow;
  assign bus.out_zero   = r_zero;
endmodule
